// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and index-width helper for the fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fetch_imem.sv
// fetch_imem: instruction RAM with one registered read port and one loader write port
module fetch_imem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW = idx_w(DEPTH)
) (
  input  logic            clock,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] mem [DEPTH];
  // write and registered read share the edge; a colliding read sees the old word
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-based instruction fetch with redirect flush and a decode-side output queue
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              IMEM_DEPTH = 256,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              QDEPTH     = 2,
  localparam int             AW         = idx_w(IMEM_DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            imem_we,
  input  logic [AW-1:0]   imem_waddr,
  input  logic [XLEN-1:0] imem_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4
);
  localparam int PW = idx_w(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0] QD = (CW + 1)'(QDEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] pc, tag_pc, last_instr, last_pc, rdata;
  logic            inflight, pop, issue, enq;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic [PW-1:0]   head, tail;
  logic [XLEN-1:0] q_instr [QDEPTH];
  logic [XLEN-1:0] q_pc    [QDEPTH];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = count != '0;
  assign out_instr = out_valid ? q_instr[head] : last_instr;
  assign out_pc    = out_valid ? q_pc[head] : last_pc;
  assign out_pc4   = out_pc + STEP;
  assign pop       = out_valid & out_ready;
  assign enq       = inflight & ~redirect;
  assign occ       = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
  assign issue     = ~redirect & (occ < QD);

  fetch_imem #(.DEPTH(IMEM_DEPTH)) u_imem (
    .clock (clock),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .re    (issue),
    .raddr (pc[AW+1:2]),
    .rdata (rdata)
  );

  // fetch PC, in-flight tag, queue bookkeeping and the value held while the queue is empty
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      tag_pc     <= '0;
      inflight   <= 1'b0;
      count      <= '0;
      head       <= '0;
      tail       <= '0;
      last_instr <= NOP;
      last_pc    <= '0;
    end else begin
      last_instr <= out_instr;
      last_pc    <= out_pc;
      if (redirect) begin
        pc       <= redirect_pc & ~XLEN'(3);
        inflight <= 1'b0;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          pc     <= pc + STEP;
          tag_pc <= pc;
        end
        if (enq) tail <= nxt(tail);
        if (pop) head <= nxt(head);
        count <= count + CW'(enq) - CW'(pop);
      end
    end
  end

  // queue payload lands the cycle after its read was issued
  always_ff @(posedge clock) begin
    if (enq) begin
      q_instr[tail] <= rdata;
      q_pc[tail]    <= tag_pc;
    end
  end
endmodule
